// File: rtl/core_pkg.sv
// Shared types for the core register-file writeback slice.
package core_pkg;

  typedef logic [4:0] regaddr_t;

  localparam int NREGS = 32;

  // Encodings double as bit positions in the arbiter request/grant vectors.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/core_rr_arb2.sv
// Two-requester round-robin arbiter, combinational grant; alternates on contention.
// No backpressure: the grant depends only on the current requests and the last-grant flop.
module core_rr_arb2
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == SRC_MEM) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= SRC_MEM;
    end else if (gnt[SRC_ALU]) begin
      last_grant <= SRC_ALU;
    end else if (gnt[SRC_MEM]) begin
      last_grant <= SRC_MEM;
    end
  end

endmodule

// File: rtl/core_regwb.sv
// Register-file writer: round-robin ALU/load results into a registered write port, 1-cycle latency.
// Never back-pressures its sources; issue stalls only when the pending counter of issue_rd saturates.
module core_regwb
  import core_pkg::*;
#(
  parameter int PEND_W = 2,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  regaddr_t        issue_rd,
  output logic            issue_ready,
  input  regaddr_t        qaddr1,
  input  regaddr_t        qaddr2,
  output logic            busy1,
  output logic            busy2,
  input  logic            alu_valid,
  input  regaddr_t        alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  regaddr_t        mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output regaddr_t        waddr,
  output logic [XLEN-1:0] wdata,
  output logic            wen,
  output logic            err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [1:0]       req;
  logic [1:0]       gnt;
  regaddr_t         sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic [PEND_W-1:0] pend [NREGS];
  logic [NREGS-1:0] inc_vec;
  logic [NREGS-1:0] dec_vec;
  logic             inc;

  assign req[SRC_ALU] = alu_valid;
  assign req[SRC_MEM] = mem_valid;

  core_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign alu_ready = gnt[SRC_ALU];
  assign mem_ready = gnt[SRC_MEM];

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (gnt[SRC_MEM]) begin
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end
  end

  // Write stage. x0 results still consume the grant but never raise wen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      waddr <= '0;
      wdata <= '0;
      wen   <= 1'b0;
    end else if (|gnt) begin
      waddr <= sel_rd;
      wdata <= sel_data;
      wen   <= (sel_rd != '0);
    end else begin
      wen   <= 1'b0;
    end
  end

  assign issue_ready = (issue_rd == '0) || (pend[issue_rd] != PEND_MAX);
  assign inc         = issue_valid && issue_ready && (issue_rd != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc) inc_vec[issue_rd] = 1'b1;
    if (wen) dec_vec[waddr]    = 1'b1;
  end

  // Decrement lands on the same edge the regfile latches wdata, so busy needs no bypass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) pend[r] <= '0;
      err <= 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          pend[r] <= pend[r] + 1'b1;
        end else if (dec_vec[r] && !inc_vec[r] && pend[r] != '0) begin
          pend[r] <= pend[r] - 1'b1;
        end
      end
      if (wen && pend[waddr] == '0) err <= 1'b1;
    end
  end

  assign busy1 = (qaddr1 != '0) && (pend[qaddr1] != '0);
  assign busy2 = (qaddr2 != '0) && (pend[qaddr2] != '0);

endmodule

// File: tb/tb_core_regwb.sv
// Directed bench for core_regwb: hand-computed expectations checked with immediate assertions.
module tb_core_regwb;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  regaddr_t    issue_rd;
  logic        issue_ready;
  regaddr_t    qaddr1, qaddr2;
  logic        busy1, busy2;
  logic        alu_valid;
  regaddr_t    alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  regaddr_t    mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  regaddr_t    waddr;
  logic [31:0] wdata;
  logic        wen;
  logic        err;

  int ntests = 0;
  int nfail  = 0;

  core_regwb #(.PEND_W(2), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .qaddr1      (qaddr1),
    .qaddr2      (qaddr2),
    .busy1       (busy1),
    .busy2       (busy2),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .waddr       (waddr),
    .wdata       (wdata),
    .wen         (wen),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; issue_valid = 1'b0; issue_rd = '0; qaddr1 = '0; qaddr2 = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;

    // 1: reset state
    step(); step();
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    for (int q = 0; q < 32; q++) begin
      qaddr1 = regaddr_t'(q); qaddr2 = regaddr_t'(31 - q); #1;
      chk("rst_busy1", {31'd0, busy1}, 32'd0);
      chk("rst_busy2", {31'd0, busy2}, 32'd0);
    end
    rst = 1'b1;
    step();

    // 2: issue then ALU commit to x5
    issue_valid = 1'b1; issue_rd = 5'd5; #1;
    chk("t2_issue_ready", {31'd0, issue_ready}, 32'd1);
    step();
    issue_valid = 1'b0; qaddr1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; #1;
    chk("t2_busy_pre", {31'd0, busy1}, 32'd1);
    chk("t2_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("t2_mem_ready", {31'd0, mem_ready}, 32'd0);
    step();
    alu_valid = 1'b0; #1;
    chk("t2_wen", {31'd0, wen}, 32'd1);
    chk("t2_waddr", {27'd0, waddr}, 32'd5);
    chk("t2_wdata", wdata, 32'hDEADBEEF);
    chk("t2_busy_wen", {31'd0, busy1}, 32'd1);
    step();
    chk("t2_wen_off", {31'd0, wen}, 32'd0);
    chk("t2_busy_post", {31'd0, busy1}, 32'd0);
    chk("t2_err", {31'd0, err}, 32'd0);

    // 3: contention after reset, ALU first
    rst = 1'b0; step(); rst = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd3; step();
    issue_rd = 5'd4; step();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22; #1;
    chk("t3_g1_alu", {31'd0, alu_ready}, 32'd1);
    chk("t3_g1_mem", {31'd0, mem_ready}, 32'd0);
    step();
    chk("t3_w1_wen", {31'd0, wen}, 32'd1);
    chk("t3_w1_addr", {27'd0, waddr}, 32'd3);
    chk("t3_w1_data", wdata, 32'h11);
    chk("t3_g2_alu", {31'd0, alu_ready}, 32'd0);
    chk("t3_g2_mem", {31'd0, mem_ready}, 32'd1);
    step();
    chk("t3_w2_wen", {31'd0, wen}, 32'd1);
    chk("t3_w2_addr", {27'd0, waddr}, 32'd4);
    chk("t3_w2_data", wdata, 32'h22);
    chk("t3_g3_alu", {31'd0, alu_ready}, 32'd1);
    alu_valid = 1'b0; mem_valid = 1'b0;
    step();
    chk("t3_wen_off", {31'd0, wen}, 32'd0);
    chk("t3_err", {31'd0, err}, 32'd0);

    // 4: saturation of x7's pending counter
    issue_valid = 1'b1; issue_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_issue_ok", {31'd0, issue_ready}, 32'd1);
      step();
    end
    issue_valid = 1'b0; #1;
    chk("t4_sat7", {31'd0, issue_ready}, 32'd0);
    issue_rd = 5'd8; #1;
    chk("t4_free8", {31'd0, issue_ready}, 32'd1);
    issue_rd = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    step();
    alu_valid = 1'b0; #1;
    chk("t4_wen7", {31'd0, wen}, 32'd1);
    chk("t4_no_credit", {31'd0, issue_ready}, 32'd0);
    step();
    chk("t4_ready_back", {31'd0, issue_ready}, 32'd1);
    alu_valid = 1'b1; step();
    alu_valid = 1'b0; issue_valid = 1'b1; #1;
    chk("t4_same_wen", {31'd0, wen}, 32'd1);
    chk("t4_same_ready", {31'd0, issue_ready}, 32'd1);
    step();
    issue_valid = 1'b0; #1;
    chk("t4_pend2_ready", {31'd0, issue_ready}, 32'd1);
    issue_valid = 1'b1; step();
    issue_valid = 1'b0; #1;
    chk("t4_pend3_sat", {31'd0, issue_ready}, 32'd0);

    // 5: x0 result from the load unit
    qaddr1 = 5'd7; qaddr2 = 5'd0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h55; #1;
    chk("t5_mem_ready", {31'd0, mem_ready}, 32'd1);
    step();
    mem_valid = 1'b0; #1;
    chk("t5_wen", {31'd0, wen}, 32'd0);
    chk("t5_busy7", {31'd0, busy1}, 32'd1);
    chk("t5_busy0", {31'd0, busy2}, 32'd0);
    step();
    chk("t5_err", {31'd0, err}, 32'd0);

    // 6: commit without issue, then reset mid-stream
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; step();
    alu_valid = 1'b0; #1;
    chk("t6_wen9", {31'd0, wen}, 32'd1);
    chk("t6_err_pre", {31'd0, err}, 32'd0);
    step();
    chk("t6_err_set", {31'd0, err}, 32'd1);
    step(); step();
    chk("t6_err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b0; alu_valid = 1'b1; alu_rd = 5'd7; step();
    chk("t6_rst_err", {31'd0, err}, 32'd0);
    chk("t6_rst_wen", {31'd0, wen}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy1}, 32'd0);
    rst = 1'b1; alu_valid = 1'b0; step();
    chk("t6_post_wen", {31'd0, wen}, 32'd0);
    chk("t6_post_err", {31'd0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
